// File: rtl/regfile_alu_pipe_if.sv
// Instruction/result/debug bundle between a sequencer (master) and the
// regfile_alu_pipe execution unit (slave).
interface regfile_alu_pipe_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
);
    localparam int AW = $clog2(NREGS);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [AW-1:0]    src_a;
    logic [AW-1:0]    src_b;
    logic [AW-1:0]    dst;
    logic             wr_en;
    logic [WIDTH-1:0] in_data;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    logic [AW-1:0]    dbg_sel;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output in_valid, op, src_a, src_b, dst, wr_en, in_data,
        output out_ready, dbg_sel,
        input  in_ready, out_valid, result,
        input  flag_z, flag_n, flag_c, flag_v, dbg_data
    );

    modport slave (
        input  in_valid, op, src_a, src_b, dst, wr_en, in_data,
        input  out_ready, dbg_sel,
        output in_ready, out_valid, result,
        output flag_z, flag_n, flag_c, flag_v, dbg_data
    );
endinterface

// File: rtl/regfile_alu_pipe.sv
// Two-stage register-file/ALU execution unit: operand read with EX bypass at
// issue, then execute/writeback into a registered result with valid/ready.
module regfile_alu_pipe #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_alu_pipe_if.slave   bus
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SLL  = 3'd5,
        OP_SRL  = 3'd6,
        OP_LOAD = 3'd7
    } op_e;

    // Architectural registers (flops, since reset must clear every entry).
    logic [WIDTH-1:0] rf_reg [NREGS];

    // EX stage
    logic             ex_valid_reg;
    op_e              ex_op_reg;
    logic [WIDTH-1:0] ex_a_reg;
    logic [WIDTH-1:0] ex_b_reg;
    logic [AW-1:0]    ex_dst_reg;
    logic             ex_wr_en_reg;
    logic [WIDTH-1:0] ex_imm_reg;

    // OUT stage
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             flag_z_reg;
    logic             flag_n_reg;
    logic             flag_c_reg;
    logic             flag_v_reg;

    logic             advance;
    logic [WIDTH-1:0] alu_result;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [SW-1:0]    shamt;
    logic             ex_writes;
    logic             fwd_a;
    logic             fwd_b;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [NREGS-1:0] wr_sel;

    // The whole pipe moves together; only the result side can stall it.
    assign advance      = !out_valid_reg || bus.out_ready;
    assign bus.in_ready = advance;

    assign sum_ext = {1'b0, ex_a_reg} + {1'b0, ex_b_reg};
    assign diff    = ex_a_reg - ex_b_reg;
    assign shamt   = ex_b_reg[SW-1:0];

    always_comb begin
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (ex_op_reg)
            OP_ADD: begin
                alu_result = sum_ext[WIDTH-1:0];
                alu_c      = sum_ext[WIDTH];
                alu_v      = (ex_a_reg[WIDTH-1] == ex_b_reg[WIDTH-1]) &&
                             (sum_ext[WIDTH-1] != ex_a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = diff;
                alu_c      = (ex_a_reg >= ex_b_reg);
                alu_v      = (ex_a_reg[WIDTH-1] != ex_b_reg[WIDTH-1]) &&
                             (diff[WIDTH-1] != ex_a_reg[WIDTH-1]);
            end
            OP_AND:  alu_result = ex_a_reg & ex_b_reg;
            OP_OR:   alu_result = ex_a_reg | ex_b_reg;
            OP_XOR:  alu_result = ex_a_reg ^ ex_b_reg;
            OP_SLL:  alu_result = ex_a_reg << shamt;
            OP_SRL:  alu_result = ex_a_reg >> shamt;
            OP_LOAD: alu_result = ex_imm_reg;
            default: alu_result = '0;
        endcase
    end

    // Only a valid, writing EX instruction may act as a bypass source.
    assign ex_writes = ex_valid_reg && ex_wr_en_reg;
    assign fwd_a     = ex_writes && (ex_dst_reg == bus.src_a);
    assign fwd_b     = ex_writes && (ex_dst_reg == bus.src_b);
    assign opnd_a    = fwd_a ? alu_result : rf_reg[bus.src_a];
    assign opnd_b    = fwd_b ? alu_result : rf_reg[bus.src_b];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_sel
            assign wr_sel[gi] = advance && ex_writes && (ex_dst_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_sel[i]) begin
                    rf_reg[i] <= alu_result;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg <= 1'b0;
            ex_op_reg    <= OP_ADD;
            ex_a_reg     <= '0;
            ex_b_reg     <= '0;
            ex_dst_reg   <= '0;
            ex_wr_en_reg <= 1'b0;
            ex_imm_reg   <= '0;
        end else if (advance) begin
            ex_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                ex_op_reg    <= op_e'(bus.op);
                ex_a_reg     <= opnd_a;
                ex_b_reg     <= opnd_b;
                ex_dst_reg   <= bus.dst;
                ex_wr_en_reg <= bus.wr_en;
                ex_imm_reg   <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            flag_z_reg    <= 1'b0;
            flag_n_reg    <= 1'b0;
            flag_c_reg    <= 1'b0;
            flag_v_reg    <= 1'b0;
        end else if (advance) begin
            out_valid_reg <= ex_valid_reg;
            if (ex_valid_reg) begin
                result_reg <= alu_result;
                flag_z_reg <= (alu_result == '0);
                flag_n_reg <= alu_result[WIDTH-1];
                flag_c_reg <= alu_c;
                flag_v_reg <= alu_v;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.flag_z    = flag_z_reg;
    assign bus.flag_n    = flag_n_reg;
    assign bus.flag_c    = flag_c_reg;
    assign bus.flag_v    = flag_v_reg;
    // Architectural view only: an instruction still in EX is not visible here.
    assign bus.dbg_data  = rf_reg[bus.dbg_sel];
endmodule

// File: doc/regfile_alu_pipe.md
# regfile_alu_pipe

Parametrised register-file/ALU execution unit with a 2-stage pipeline (operand read, execute/writeback), operand bypass and valid/ready flow control on both the instruction and result sides. It is the datapath core of the team's small-processor exercises: a sequencer issues one instruction per cycle and a consumer drains results. Instructions run back to back with no bubbles unless the result side applies backpressure.

## Interface
- WIDTH, 16, data and register width (≥4)
- NREGS, 8, register count, power of two ≥2; AW = clog2(NREGS), SW = clog2(WIDTH)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  instruction accepted when in_valid && in_ready at a clk edge
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 LOAD
- src_a, src_b  in  AW  operand register indices
- dst  in  AW  destination register index
- wr_en  in  1  1 = write result to rf[dst]; 0 = result/flags only
- in_data  in  WIDTH  immediate for LOAD
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes result when out_valid && out_ready
- result  out  WIDTH  registered result
- flag_z, flag_n, flag_c, flag_v  out  1 each  registered zero/negative/carry/overflow
- dbg_sel  in  AW  debug read index
- dbg_data  out  WIDTH  combinational rf[dbg_sel] (architectural value, no bypass)

## Operation
- Stages: ISSUE (accept, read operands) -> EX register (ex_valid, op, a, b, dst, wr_en, imm) -> OUT register (result, flags, out_valid).
- advance = !out_valid || out_ready; in_ready = advance.
- On advance: if ex_valid, ALU result of EX goes to OUT, out_valid=1, and if ex wr_en, rf[ex_dst] <= result at the same edge; else out_valid <= 0 unless consumed... precisely: out_valid <= ex_valid. EX <= accepted instruction; ex_valid <= in_valid.
- No advance: EX, OUT, regfile all hold; no write occurs.
- Operand read at issue: if ex_valid && ex_wr_en && ex_dst == src, use EX ALU output (bypass); else rf[src]. Applies independently to a and b.
- ALU (unsigned WIDTH-bit, wrap modulo 2^WIDTH): ADD a+b, c = carry out, v = signed overflow; SUB a-b, c = 1 iff a ≥ b unsigned, v = signed overflow; AND/OR/XOR bitwise; SLL a << b[SW-1:0]; SRL a >> b[SW-1:0] logical; LOAD = in_data. c and v are 0 for ops 2–7.
- flag_z = (result == 0); flag_n = result[WIDTH-1]; for all ops.
- wr_en=0: result/flags produced, no register change, no bypass source.

## Timing
- Reset (async, any time, including mid-stall): all rf entries 0, ex_valid 0, out_valid 0, result 0, all flags 0; in_ready 1 after reset since out_valid=0. Instructions in flight are discarded.
- Latency: instruction accepted at edge k -> result/flags visible and out_valid=1 after edge k+1; register write lands at edge k+1 (dbg_data shows it from then).
- Throughput one instruction per cycle with out_ready held 1; dependent back-to-back instructions need no stall (bypass).
- Dependency two instructions apart reads the register file (already written).
- in_ready is combinational from out_valid/out_ready only, never from in_valid.
- Stall: out_valid && !out_ready -> in_ready=0; result and flags stable until taken.
- Same dst written twice in a row: later write wins; bypass always reflects the EX instruction.

## Test plan
- Reset: drive rst_n=0 mid-stream with out_valid=1 -> out_valid 0, result 0, flags 0, dbg_data 0 for every dbg_sel, in_ready 1.
- Back-to-back bypass (WIDTH=16): LOAD r0=50, LOAD r1=30, ADD r2=r0+r1, SUB r3=r2-r1 consecutive cycles -> results 50,30,80,50 on consecutive cycles; rf r2=80, r3=50.
- Flags: ADD 0x7FFF+0x0001 -> 0x8000, n=1, v=1, c=0; ADD 0xFFFF+0x0001 -> 0, z=1, c=1; SUB 3-5 -> 0xFFFE, c=0, n=1.
- Shifts/logic: SLL 0x0001 by b=0x0013 -> 0x0008 (amount 3); SRL 0x8000 by 15 -> 0x0001; XOR 0xF0F0^0xFFFF -> 0x0F0F.
- Backpressure: hold out_ready=0 for 3 cycles after first result -> in_ready 0, result stable, no rf change for the EX instruction until release; after release sequence completes with no loss or duplication.
- wr_en=0 and parameters: ADD with wr_en=0, dst=r4 -> result out, rf[r4] unchanged, next instruction reading r4 gets old value; repeat LOAD/ADD sequence with WIDTH=32, NREGS=16.
